// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
//
// Purpose:
//   Multi-cycle stage controller for the non-pipelined core. Each instruction
//   walks IF -> IF_ID -> ID -> ID_EX -> EX_MEM -> [MEM] -> MEM_WB -> WB -> WB_IF.
//   The controller drives one-hot write enables for the pipeline registers, the
//   data RAM and the register file. It also provides:
//     - minimum IF/MEM dwell times combined with memory ready handshakes;
//     - MEM skip for non-memory instructions;
//     - halt/resume;
//     - a single-step pause;
//     - a retired-instruction counter.
//
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   imem_ready        instruction memory data valid (gates leaving IF)
//   dmem_ready        data memory access complete (gates leaving MEM)
//   mem_op            instruction uses MEM; sampled in EX_MEM
//   halt_req          stop after current instruction; sampled in WB_IF
//   resume            leave HALT
//   step_en           single-step mode; sampled in WB_IF, falling exits PAUSE
//   step_go           run one instruction from PAUSE
//   *_wren            pipeline register / RAM / regfile write enables
//   stage_reset_n     active-low reset to the stage registers (low in INIT)
//   stage             current state encoding
//   halted, paused    state is HALT / PAUSE
//   instr_count       retired instructions, wraps modulo 2^ICNT_W
// -----------------------------------------------------------------------------
module stage_sequencer #(
    parameter int IF_CYCLES  = 1,
    parameter int MEM_CYCLES = 1,
    parameter int CNT_W      = 4,
    parameter int ICNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              imem_ready,
    input  logic              dmem_ready,
    input  logic              mem_op,
    input  logic              halt_req,
    input  logic              resume,
    input  logic              step_en,
    input  logic              step_go,
    output logic              pc_wren,
    output logic              wb_if_wren,
    output logic              if_id_wren,
    output logic              id_ex_wren,
    output logic              ex_mem_wren,
    output logic              mem_wb_wren,
    output logic              ram_wren,
    output logic              reg_wren,
    output logic              stage_reset_n,
    output logic [3:0]        stage,
    output logic              halted,
    output logic              paused,
    output logic [ICNT_W-1:0] instr_count
);

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_IF     = 4'd1;
    localparam logic [3:0] S_IF_ID  = 4'd2;
    localparam logic [3:0] S_ID     = 4'd3;
    localparam logic [3:0] S_ID_EX  = 4'd4;
    localparam logic [3:0] S_EX_MEM = 4'd5;
    localparam logic [3:0] S_MEM    = 4'd6;
    localparam logic [3:0] S_MEM_WB = 4'd7;
    localparam logic [3:0] S_WB     = 4'd8;
    localparam logic [3:0] S_WB_IF  = 4'd9;
    localparam logic [3:0] S_PAUSE  = 4'd10;
    localparam logic [3:0] S_HALT   = 4'd11;

    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ICNT_W-1:0] ICNT_ONE = {{(ICNT_W-1){1'b0}}, 1'b1};
    // Last wait_cnt value before a dwell is satisfied (count starts at 0).
    localparam logic [CNT_W-1:0]  IF_LAST  = CNT_W'(IF_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MEM_LAST = CNT_W'(MEM_CYCLES - 1);

    logic [3:0]        state_q, state_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:   state_d = S_IF;
            S_IF:     if (wait_cnt_q >= IF_LAST && imem_ready) state_d = S_IF_ID;
            S_IF_ID:  state_d = S_ID;
            S_ID:     state_d = S_ID_EX;
            S_ID_EX:  state_d = S_EX_MEM;
            S_EX_MEM: state_d = mem_op ? S_MEM : S_MEM_WB;
            S_MEM:    if (wait_cnt_q >= MEM_LAST && dmem_ready) state_d = S_MEM_WB;
            S_MEM_WB: state_d = S_WB;
            S_WB:     state_d = S_WB_IF;
            // halt_req outranks step_en when both are seen at the boundary.
            S_WB_IF: begin
                if (halt_req)     state_d = S_HALT;
                else if (step_en) state_d = S_PAUSE;
                else              state_d = S_IF;
            end
            // Dropping step_en while paused releases the core like step_go.
            S_PAUSE:  if (step_go || !step_en) state_d = S_IF;
            S_HALT:   if (resume) state_d = S_IF;
            default:  state_d = S_INIT;
        endcase
    end

    // Dwell counter restarts on every transition and saturates so a long
    // memory stall cannot wrap it back below the threshold.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if ((state_q == S_IF || state_q == S_MEM) && wait_cnt_q != CNT_MAX) begin
            wait_cnt_d = wait_cnt_q + CNT_ONE;
        end
    end

    always_comb begin
        icnt_d = icnt_q;
        if (state_q == S_WB_IF) icnt_d = icnt_q + ICNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_INIT;
            wait_cnt_q <= '0;
            icnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            icnt_q     <= icnt_d;
        end
    end

    // Moore decode: everything below depends on registers only.
    always_comb begin
        pc_wren       = 1'b0;
        wb_if_wren    = 1'b0;
        if_id_wren    = 1'b0;
        id_ex_wren    = 1'b0;
        ex_mem_wren   = 1'b0;
        mem_wb_wren   = 1'b0;
        ram_wren      = 1'b0;
        reg_wren      = 1'b0;
        stage_reset_n = (state_q != S_INIT);
        case (state_q)
            S_IF_ID:  if_id_wren  = 1'b1;
            S_ID_EX:  id_ex_wren  = 1'b1;
            S_EX_MEM: ex_mem_wren = 1'b1;
            // Single write strobe on MEM entry, even if MEM is extended.
            S_MEM:    ram_wren    = (wait_cnt_q == '0);
            S_MEM_WB: mem_wb_wren = 1'b1;
            S_WB:     reg_wren    = 1'b1;
            S_WB_IF: begin
                wb_if_wren = 1'b1;
                pc_wren    = 1'b1;
            end
            default: ;
        endcase
    end

    assign stage       = state_q;
    assign halted      = (state_q == S_HALT);
    assign paused      = (state_q == S_PAUSE);
    assign instr_count = icnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
module tb_stage_sequencer;

    localparam int ST_INIT = 0, ST_IF = 1, ST_IF_ID = 2, ST_ID = 3, ST_ID_EX = 4,
                   ST_EX_MEM = 5, ST_MEM = 6, ST_MEM_WB = 7, ST_WB = 8,
                   ST_WB_IF = 9, ST_PAUSE = 10, ST_HALT = 11;

    logic clk;
    logic reset_n, imem_ready, dmem_ready, mem_op, halt_req, resume, step_en, step_go;

    // Enable bit order: 0 pc, 1 wb_if, 2 if_id, 3 id_ex, 4 ex_mem, 5 mem_wb, 6 ram, 7 reg
    wire [7:0]  en1, en3;
    wire        srn1, srn3, h1, h3, p1, p3;
    wire [3:0]  stg1, stg3;
    wire [31:0] cnt1, cnt3;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 0;

    stage_sequencer #(.IF_CYCLES(1), .MEM_CYCLES(1), .CNT_W(4), .ICNT_W(32)) d1 (
        .clk(clk), .reset_n(reset_n), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .mem_op(mem_op), .halt_req(halt_req), .resume(resume), .step_en(step_en),
        .step_go(step_go), .pc_wren(en1[0]), .wb_if_wren(en1[1]), .if_id_wren(en1[2]),
        .id_ex_wren(en1[3]), .ex_mem_wren(en1[4]), .mem_wb_wren(en1[5]),
        .ram_wren(en1[6]), .reg_wren(en1[7]), .stage_reset_n(srn1), .stage(stg1),
        .halted(h1), .paused(p1), .instr_count(cnt1)
    );

    stage_sequencer #(.IF_CYCLES(3), .MEM_CYCLES(2), .CNT_W(4), .ICNT_W(32)) d3 (
        .clk(clk), .reset_n(reset_n), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .mem_op(mem_op), .halt_req(halt_req), .resume(resume), .step_en(step_en),
        .step_go(step_go), .pc_wren(en3[0]), .wb_if_wren(en3[1]), .if_id_wren(en3[2]),
        .id_ex_wren(en3[3]), .ex_mem_wren(en3[4]), .mem_wb_wren(en3[5]),
        .ram_wren(en3[6]), .reg_wren(en3[7]), .stage_reset_n(srn3), .stage(stg3),
        .halted(h3), .paused(p3), .instr_count(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Per instance: current stage, cycles already spent in it, retired count.
    int          m_stage [2];
    int          m_dwell [2];
    logic [31:0] m_cnt   [2];
    int          ov_st_req = 0, ov_st_seen = 0, ov_st_val = 0;
    int          ov_cnt_req = 0, ov_cnt_seen = 0;

    function automatic int min_if(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int min_mem(int k);
        return (k == 0) ? 1 : 2;
    endfunction

    function automatic int model_next(int s, int dwell, int k);
        case (s)
            ST_INIT:   return ST_IF;
            ST_IF:     return (dwell + 1 >= min_if(k) && imem_ready) ? ST_IF_ID : ST_IF;
            ST_IF_ID:  return ST_ID;
            ST_ID:     return ST_ID_EX;
            ST_ID_EX:  return ST_EX_MEM;
            ST_EX_MEM: return mem_op ? ST_MEM : ST_MEM_WB;
            ST_MEM:    return (dwell + 1 >= min_mem(k) && dmem_ready) ? ST_MEM_WB : ST_MEM;
            ST_MEM_WB: return ST_WB;
            ST_WB:     return ST_WB_IF;
            ST_WB_IF:  return halt_req ? ST_HALT : (step_en ? ST_PAUSE : ST_IF);
            ST_PAUSE:  return (step_go || !step_en) ? ST_IF : ST_PAUSE;
            ST_HALT:   return resume ? ST_IF : ST_HALT;
            default:   return ST_INIT;
        endcase
    endfunction

    function automatic logic [7:0] exp_en(int s, int dwell);
        logic [7:0] m;
        m = 8'h00;
        case (s)
            ST_IF_ID:  m[2] = 1'b1;
            ST_ID_EX:  m[3] = 1'b1;
            ST_EX_MEM: m[4] = 1'b1;
            ST_MEM:    m[6] = (dwell == 0);
            ST_MEM_WB: m[5] = 1'b1;
            ST_WB:     m[7] = 1'b1;
            ST_WB_IF:  m[1:0] = 2'b11;
            default:   m = 8'h00;
        endcase
        return m;
    endfunction

    // {stage_reset_n, halted, paused}
    function automatic logic [2:0] exp_ctl(int s);
        return {s != ST_INIT, s == ST_HALT, s == ST_PAUSE};
    endfunction

    always @(posedge clk) begin
        int ns;
        if (ov_st_req != ov_st_seen) begin
            m_stage[0] = ov_st_val;
            ov_st_seen = ov_st_req;
        end
        if (ov_cnt_req != ov_cnt_seen) begin
            m_cnt[0]    = 32'hFFFF_FFFF;
            ov_cnt_seen = ov_cnt_req;
        end
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                m_stage[k] = ST_INIT;
                m_dwell[k] = 0;
                m_cnt[k]   = 32'd0;
            end else begin
                ns = model_next(m_stage[k], m_dwell[k], k);
                if (m_stage[k] == ST_WB_IF) m_cnt[k] = m_cnt[k] + 32'd1;
                m_dwell[k] = (ns == m_stage[k]) ? m_dwell[k] + 1 : 0;
                m_stage[k] = ns;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (chk_on) begin
            check("stage_d1", 32'(stg1), 32'(m_stage[0]));
            check("enables_d1", 32'(en1), 32'(exp_en(m_stage[0], m_dwell[0])));
            check("ctl_d1", 32'({srn1, h1, p1}), 32'(exp_ctl(m_stage[0])));
            check("count_d1", cnt1, m_cnt[0]);
            check("stage_d3", 32'(stg3), 32'(m_stage[1]));
            check("enables_d3", 32'(en3), 32'(exp_en(m_stage[1], m_dwell[1])));
            check("ctl_d3", 32'({srn3, h3, p3}), 32'(exp_ctl(m_stage[1])));
            check("count_d3", cnt3, m_cnt[1]);
        end
    end

    // ---------------- directed + random stimulus ----------------
    function automatic int cur_stage(int which);
        return (which == 0) ? int'(stg1) : int'(stg3);
    endfunction

    // Advance at least one cycle, then until the instance shows stage s.
    task automatic wait_stage(input int which, input int s, input int limit, input string tag);
        int i;
        i = 0;
        do begin
            @(posedge clk); #1;
            i++;
        end while (cur_stage(which) != s && i < limit);
        if (cur_stage(which) != s) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s: timeout, stage %0d, wanted %0d", tag, cur_stage(which), s);
        end
    endtask

    initial begin
        int cyc, ramc, ifc, n, mc;
        logic [31:0] c0;

        reset_n = 0; imem_ready = 1; dmem_ready = 1; mem_op = 1;
        halt_req = 0; resume = 0; step_en = 0; step_go = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1;
        check("rst_stage", 32'(stg1), 32'd0);
        check("rst_enables", 32'(en1), 32'd0);
        check("rst_stage_reset_n", 32'(srn1), 32'd0);
        check("rst_count", cnt1, 32'd0);

        // Memory instruction sequence: INIT then 1..9, back to IF.
        @(negedge clk) reset_n = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("seq_mem", 32'(stg1), (i < 9) ? 32'(i + 1) : 32'd1);
        end
        check("count_first", cnt1, 32'd1);

        // Non-memory instruction: 8 cycles, no RAM strobe.
        @(negedge clk) mem_op = 0;
        wait_stage(0, ST_WB_IF, 40, "nonmem_sync");
        cyc = 0; ramc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            ramc += int'(en1[6]);
        end while (stg1 != 4'd9 && cyc < 40);
        check("nonmem_cycles", 32'(cyc), 32'd8);
        check("nonmem_ram", 32'(ramc), 32'd0);

        @(negedge clk) mem_op = 1;
        cyc = 0; ramc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            ramc += int'(en1[6]);
        end while (stg1 != 4'd9 && cyc < 40);
        check("mem_cycles", 32'(cyc), 32'd9);
        check("mem_ram", 32'(ramc), 32'd1);

        // IF_CYCLES=3 instance: imem_ready low until the 5th IF cycle.
        wait_stage(1, ST_WB_IF, 60, "if_sync");
        @(negedge clk) imem_ready = 0;
        @(posedge clk); #1;
        check("if_entry_d3", 32'(stg3), 32'd1);
        ifc = 1; n = 0;
        fork
            begin
                repeat (5) @(negedge clk);
                imem_ready = 1;
            end
            begin
                do begin
                    @(posedge clk); #1;
                    n++;
                    if (stg3 == 4'd1) ifc++;
                end while (stg3 == 4'd1 && n < 20);
            end
        join
        check("if_len_d3", 32'(ifc), 32'd5);

        // MEM_CYCLES=2: two MEM cycles, RAM strobe on the first only.
        wait_stage(1, ST_MEM, 60, "mem_sync");
        mc = 1; ramc = int'(en3[6]); n = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (stg3 == 4'd6) begin
                mc++;
                ramc += int'(en3[6]);
            end
        end while (stg3 == 4'd6 && n < 20);
        check("mem_len_d3", 32'(mc), 32'd2);
        check("mem_ram_d3", 32'(ramc), 32'd1);

        // Halt has priority over step.
        wait_stage(0, ST_WB, 40, "halt_sync");
        @(negedge clk) begin halt_req = 1; step_en = 1; end
        @(posedge clk); #1;
        check("halt_wbif", 32'(stg1), 32'd9);
        @(posedge clk); #1;
        check("halt_enter", 32'({stg1, h1, p1}), {26'd0, 4'd11, 1'b1, 1'b0});
        @(negedge clk) begin halt_req = 0; step_en = 0; end
        repeat (10) begin
            @(posedge clk); #1;
            check("halt_hold", 32'({stg1, en1, h1}), {19'd0, 4'd11, 8'd0, 1'b1});
        end
        @(negedge clk) resume = 1;
        @(posedge clk); #1;
        check("resume", 32'({stg1, h1}), {27'd0, 4'd1, 1'b0});
        @(negedge clk) resume = 0;

        // Single step.
        @(negedge clk) step_en = 1;
        wait_stage(0, ST_PAUSE, 60, "pause_sync");
        check("paused", 32'(p1), 32'd1);
        c0 = m_cnt[0];
        repeat (5) begin
            @(posedge clk); #1;
            check("pause_hold", 32'({stg1, cnt1[3:0]}), {24'd0, 4'd10, c0[3:0]});
        end
        for (int s = 0; s < 2; s++) begin
            @(negedge clk) step_go = 1;
            @(posedge clk); #1;
            check("step_go_if", 32'(stg1), 32'd1);
            @(negedge clk) step_go = 0;
            wait_stage(0, ST_PAUSE, 40, "step_return");
            c0 = c0 + 32'd1;
            check("step_count", cnt1, c0);
        end
        @(negedge clk) step_en = 0;
        @(posedge clk); #1;
        check("step_en_fall", 32'(stg1), 32'd1);

        // Reset in MEM aborts.
        wait_stage(0, ST_MEM, 40, "rst_mem_sync");
        @(negedge clk) reset_n = 0;
        @(posedge clk); #1;
        check("rst_mem_stage", 32'(stg1), 32'd0);
        check("rst_mem_count", cnt1, 32'd0);
        @(negedge clk) reset_n = 1;

        // Illegal encoding returns to INIT.
        @(negedge clk);
        force d1.state_q = 4'd13;
        #1;
        check("illegal_forced", 32'(stg1), 32'd13);
        release d1.state_q;
        ov_st_val = 13;
        ov_st_req++;
        @(posedge clk); #1;
        check("illegal_recover", 32'(stg1), 32'd0);

        // Counter wrap.
        wait_stage(0, ST_IF_ID, 20, "wrap_sync");
        @(negedge clk);
        force d1.icnt_q = 32'hFFFF_FFFF;
        #1;
        release d1.icnt_q;
        ov_cnt_req++;
        wait_stage(0, ST_WB_IF, 40, "wrap_wbif");
        @(posedge clk); #1;
        check("count_wrap", cnt1, 32'd0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            reset_n    = ($urandom % 150) != 0;
            imem_ready = ($urandom % 3) != 0;
            dmem_ready = ($urandom % 3) != 0;
            mem_op     = $urandom % 2;
            halt_req   = ($urandom % 8) == 0;
            resume     = ($urandom % 6) == 0;
            step_en    = ($urandom % 4) == 0;
            step_go    = ($urandom % 5) == 0;
        end
        @(negedge clk) reset_n = 1;
        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Parametrised multi-cycle stage controller for the non-pipelined core.
- Steps each instruction through IF → IF_ID → ID → ID_EX → EX_MEM → MEM → MEM_WB → WB → WB_IF and drives one-hot pipeline-register and RAM/regfile write enables.
- Adds over the previous generation:
  - configurable minimum fetch/memory cycles with ready handshakes;
  - MEM skip for non-memory instructions;
  - halt/resume;
  - single-step pause;
  - retired-instruction counter.

Parameters:
IF_CYCLES, 1, minimum cycles spent in IF (1..2^CNT_W-1)
MEM_CYCLES, 1, minimum cycles spent in MEM (1..2^CNT_W-1)
CNT_W, 4, width of internal wait counter
ICNT_W, 32, width of retired-instruction counter

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
imem_ready  input  1  instruction memory data valid
dmem_ready  input  1  data memory access complete
mem_op  input  1  current instruction uses MEM (load/store); sampled in EX_MEM
halt_req  input  1  stop after current instruction; sampled in WB_IF
resume  input  1  leave HALT
step_en  input  1  single-step mode enable; sampled in WB_IF
step_go  input  1  advance one instruction from PAUSE
pc_wren  output  1  PC update enable
wb_if_wren  output  1  WB/IF register write enable
if_id_wren  output  1  IF/ID register write enable
id_ex_wren  output  1  ID/EX register write enable
ex_mem_wren  output  1  EX/MEM register write enable
mem_wb_wren  output  1  MEM/WB register write enable
ram_wren  output  1  data RAM write strobe
reg_wren  output  1  register file write enable
stage_reset_n  output  1  active-low reset to stage registers
stage  output  4  current state encoding
halted  output  1  state == HALT
paused  output  1  state == PAUSE
instr_count  output  ICNT_W  retired instructions

Behaviour:
- State encoding: INIT=0, IF=1, IF_ID=2, ID=3, ID_EX=4, EX_MEM=5, MEM=6, MEM_WB=7, WB=8, WB_IF=9, PAUSE=10, HALT=11. Encodings 12–15 go to INIT on the next clock.
- Reset (reset_n=0 at posedge):
  - state=INIT, wait_cnt=0, instr_count=0.
  - Reset mid-instruction aborts immediately; no enable is asserted the following cycle except as decoded from INIT.
- Outputs are Moore, decoded from the state register only (no input-to-output paths):
  - INIT: all enables 0, stage_reset_n=0. Every other state: stage_reset_n=1.
  - IF_ID: if_id_wren. ID_EX: id_ex_wren. EX_MEM: ex_mem_wren. MEM_WB: mem_wb_wren. WB: reg_wren.
  - WB_IF: wb_if_wren and pc_wren.
  - MEM: ram_wren=1 only while wait_cnt==0, i.e. a single-cycle strobe on MEM entry.
  - IF, ID, PAUSE, HALT: all enables 0.
- wait_cnt:
  - Cleared on every state transition.
  - Increments each cycle in IF and MEM, saturating at 2^CNT_W-1.
- Transitions:
  - INIT → IF.
  - IF → IF_ID when wait_cnt ≥ IF_CYCLES-1 and imem_ready; otherwise stay in IF.
  - IF_ID → ID → ID_EX → EX_MEM unconditionally.
  - EX_MEM → MEM if mem_op, else → MEM_WB (MEM skipped, ram_wren never pulses).
  - MEM → MEM_WB when wait_cnt ≥ MEM_CYCLES-1 and dmem_ready; otherwise stay in MEM.
  - MEM_WB → WB → WB_IF.
  - WB_IF: halt_req → HALT; else step_en → PAUSE; else → IF. halt_req takes priority over step_en.
  - PAUSE → IF when step_go. step_en falling while in PAUSE also → IF.
  - HALT → IF when resume. resume outside HALT is ignored; step_go outside PAUSE is ignored.
- instr_count: +1 on each cycle in WB_IF; wraps modulo 2^ICNT_W.
- Cycle counts with IF_CYCLES=MEM_CYCLES=1 and readies held high:
  - memory instruction: 9 cycles, IF..WB_IF;
  - non-memory instruction: 8 cycles.

Test Plan:
- Reset, then ready=1, mem_op=1, IF/MEM_CYCLES=1 → stage sequence 0,1,2,3,4,5,6,7,8,9,1…; each enable high exactly 1 cycle per instruction; instr_count=1 after the first WB_IF; stage_reset_n low only in INIT.
- mem_op=0 → EX_MEM(5) followed directly by MEM_WB(7); ram_wren never asserted; 8 cycles per instruction.
- IF_CYCLES=3, imem_ready held 0 until the 5th IF cycle → IF lasts exactly 5 cycles. MEM_CYCLES=2 with dmem_ready=1 → MEM lasts 2 cycles, ram_wren high for the first only.
- halt_req=1 and step_en=1 during WB_IF → HALT (11), halted=1, enables 0; hold 10 cycles; resume pulse → IF next cycle, halted=0.
- step_en=1 → PAUSE (10) after each WB_IF; step_go pulse → exactly one instruction runs and returns to PAUSE; instr_count advances by 1 per step_go.
- reset_n=0 asserted during MEM → INIT next cycle, instr_count=0. Force illegal stage value 13 → INIT next cycle. Preload instr_count=0xFFFFFFFF → wraps to 0 at WB_IF.
